nibble_serial_add_ctrl: RTL

//  Sequences one shared 4-bit carry adder (A_74HC283) to add two NIBBLES*4-bit

---
 rtl/nibble_serial_add_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: drives one shared 4-bit carry adder, LSB nibble first.
// Optional subtraction mode (extra sub port) when SUB_EN is defined.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
`ifdef SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout
);

  // state | meaning
  // IDLE  | waiting for start; result/cout hold the last answer
  // RUN   | one nibble added per edge, idx selects the slice
  // DONE  | single-cycle done pulse; start here re-enters RUN at once
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int W  = 4*NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES-1);

  state_t          state, state_nxt;
  logic            accept;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_reg, b_reg;
  logic            sub_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        accept    = 1'b1;
      end
      RUN:  if (idx == LAST) state_nxt = DONE;
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sub_reg <= 1'b0;
    else if (accept) sub_reg <= sub;
  end
  // Subtraction is a + ~b + ~cin, so the initial carry is inverted too.
  wire init_carry = cin ^ sub;
`else
  assign sub_reg = 1'b0;
  wire init_carry = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_reg <= op_a;
      b_reg <= op_b;
      carry <= init_carry;
      idx   <= '0;
    end else if (state == RUN) begin
      result[{idx, 2'b00} +: 4] <= add_sum;
      carry <= add_cout;
      if (idx == LAST) cout <= add_cout;
      else             idx  <= idx + 1'b1;
    end
  end

  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[{idx, 2'b00} +: 4];
      add_b   = b_reg[{idx, 2'b00} +: 4] ^ {4{sub_reg}};
      add_cin = carry;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
